// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared definitions for the data-memory arbiter and its testbench.
//   MEM_WORDS_DEFAULT : default memory depth in 32-bit words
//   req_id_t          : which requester (if any) owns the memory this cycle
//   rsp_t             : one requester's registered response (rvalid, err, rdata)
//   addr_ok()         : true when a byte address is word aligned and inside memory
package dmem_pkg;

    localparam int MEM_WORDS_DEFAULT = 256;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_CORE,
        REQ_DMA
    } req_id_t;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    // The limit is computed in 34 bits so MEM_WORDS*4 cannot wrap for large depths.
    function automatic logic addr_ok(input logic [31:0] addr, input int words);
        logic [33:0] limit;
        limit = 34'(words) << 2;
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/dmem_addr_check.sv
// dmem_addr_check
// Combinational screen for one byte address.
// Ports:
//   addr     in  32       : byte address of the granted access
//   err      out 1        : address misaligned or beyond the end of memory
//   word_idx out IDX_W    : word index addr[IDX_W+1:2]
module dmem_addr_check
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    localparam int IDX_W    = $clog2(MEM_WORDS)
) (
    input  logic [31:0]      addr,
    output logic             err,
    output logic [IDX_W-1:0] word_idx
);

    assign err      = !addr_ok(addr, MEM_WORDS);
    assign word_idx = addr[IDX_W+1:2];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares a single-port, word-addressed data memory between the core load/store
// path and a DMA port. One access is granted per cycle: the core has priority,
// but a DMA request that has been refused MAX_WAIT consecutive cycles wins the
// next contention. Misaligned or out-of-range accesses are granted and answered
// with an error but never strobe the memory.
// Ports:
//   clk, rst_n                     : clock (rising edge), async active-low reset
//   core_req/we/addr/wdata         : core request
//   core_gnt                       : core request accepted this cycle (combinational)
//   core_rvalid/err/rdata          : core response, one cycle after the grant
//   dma_*                          : same set for the DMA requester
//   MemRead, MemWrite              : memory strobes
//   mem_addr, mem_write_data       : memory address / write data (0 when idle)
//   mem_read_data                  : combinational read data from memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic        core_err,
    output logic [31:0] core_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic        dma_err,
    output logic [31:0] dma_rdata,

    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int         IDX_W      = $clog2(MEM_WORDS);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    req_id_t          gnt_id;
    logic             gnt_we;
    logic [31:0]      gnt_addr;
    logic [31:0]      gnt_wdata;
    logic             any_gnt;
    logic             chk_err;
    logic             acc_err;
    logic [IDX_W-1:0] word_idx;
    logic             unused_word_idx;

    logic [3:0]       starve_q, starve_d;
    rsp_t             granted_rsp;
    rsp_t             core_rsp_q, core_rsp_d;
    rsp_t             dma_rsp_q, dma_rsp_d;

    // DMA wins when it is alone or when it has been starved for MAX_WAIT cycles.
    always_comb begin
        gnt_id = REQ_NONE;
        if (dma_req && (!core_req || starve_q == MAX_WAIT_C)) begin
            gnt_id = REQ_DMA;
        end else if (core_req) begin
            gnt_id = REQ_CORE;
        end
    end

    assign core_gnt = (gnt_id == REQ_CORE);
    assign dma_gnt  = (gnt_id == REQ_DMA);
    assign any_gnt  = (gnt_id != REQ_NONE);

    // Granted request's fields; all zero when nobody owns the memory.
    always_comb begin
        gnt_we    = 1'b0;
        gnt_addr  = 32'h0;
        gnt_wdata = 32'h0;
        case (gnt_id)
            REQ_CORE: begin
                gnt_we    = core_we;
                gnt_addr  = core_addr;
                gnt_wdata = core_wdata;
            end
            REQ_DMA: begin
                gnt_we    = dma_we;
                gnt_addr  = dma_addr;
                gnt_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    dmem_addr_check #(
        .MEM_WORDS (MEM_WORDS)
    ) u_addr_check (
        .addr     (gnt_addr),
        .err      (chk_err),
        .word_idx (word_idx)
    );

    // The memory decodes its own word index from mem_addr; the checker's index
    // output is not needed here.
    assign unused_word_idx = ^word_idx;

    assign acc_err        = any_gnt && chk_err;
    assign MemRead        = any_gnt && !gnt_we && !acc_err;
    assign MemWrite       = any_gnt &&  gnt_we && !acc_err;
    assign mem_addr       = gnt_addr;
    assign mem_write_data = gnt_wdata;

    // Both ports capture the same response image; only the granted one keeps it.
    always_comb begin
        granted_rsp.rvalid = 1'b1;
        granted_rsp.err    = acc_err;
        granted_rsp.rdata  = MemRead ? mem_read_data : 32'h0;
        core_rsp_d         = core_gnt ? granted_rsp : '0;
        dma_rsp_d          = dma_gnt  ? granted_rsp : '0;
    end

    // A withdrawn or served DMA request restarts the starvation count.
    always_comb begin
        starve_d = starve_q;
        if (!dma_req || dma_gnt) begin
            starve_d = 4'h0;
        end else if (starve_q != MAX_WAIT_C) begin
            starve_d = starve_q + 4'h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= 4'h0;
            core_rsp_q <= '0;
            dma_rsp_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            core_rsp_q <= core_rsp_d;
            dma_rsp_q  <= dma_rsp_d;
        end
    end

    assign core_rvalid = core_rsp_q.rvalid;
    assign core_err    = core_rsp_q.err;
    assign core_rdata  = core_rsp_q.rdata;
    assign dma_rvalid  = dma_rsp_q.rvalid;
    assign dma_err     = dma_rsp_q.err;
    assign dma_rdata   = dma_rsp_q.rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed testbench for dmem_arbiter with a 256-word memory model attached.
// Memory word i holds 32'h1000_0000 + i after reset.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = 32'h0, core_wdata = 32'h0;
    logic        core_gnt, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = 32'h0, dma_wdata = 32'h0;
    logic        dma_gnt, dma_rvalid, dma_err;
    logic [31:0] dma_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MEM_WORDS (256),
        .MAX_WAIT  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_gnt       (core_gnt),
        .core_rvalid    (core_rvalid),
        .core_err       (core_err),
        .core_rdata     (core_rdata),
        .dma_req        (dma_req),
        .dma_we         (dma_we),
        .dma_addr       (dma_addr),
        .dma_wdata      (dma_wdata),
        .dma_gnt        (dma_gnt),
        .dma_rvalid     (dma_rvalid),
        .dma_err        (dma_err),
        .dma_rdata      (dma_rdata),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Memory model: combinational read, write on the rising edge.
    assign mem_read_data = mem[mem_addr[9:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < 256; w++) mem[w] <= 32'h1000_0000 + 32'(w);
        end else if (MemWrite) begin
            mem[mem_addr[9:2]] <= mem_write_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = 32'h0; dma_wdata  = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        #2 rst_n = 1'b0;
        #10;
        checks++;
        if ({core_gnt, dma_gnt, MemRead, MemWrite} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_comb: got %b expected 0000", {core_gnt, dma_gnt, MemRead, MemWrite});
        end
        checks++;
        if ({core_rvalid, core_err, dma_rvalid, dma_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {core_rvalid, core_err, dma_rvalid, dma_err});
        end
        checks++;
        if ({core_rdata, dma_rdata, mem_addr} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h expected 0", {core_rdata, dma_rdata, mem_addr});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_core_only();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h10; core_wdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({core_gnt, MemWrite, MemRead} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL core_wr_strobe: got %b expected 110", {core_gnt, MemWrite, MemRead});
        end
        checks++;
        if ({mem_addr, mem_write_data} !== {32'h10, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL core_wr_bus: got %h expected %h", {mem_addr, mem_write_data}, {32'h10, 32'hDEAD_BEEF});
        end
        tick();
        checks++;
        if ({core_rvalid, core_err, core_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL core_wr_rsp: got %b %b %h expected 1 0 0", core_rvalid, core_err, core_rdata);
        end
        core_we = 1'b0;
        #1;
        checks++;
        if ({core_gnt, MemWrite, MemRead} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL core_rd_strobe: got %b expected 101", {core_gnt, MemWrite, MemRead});
        end
        tick();
        checks++;
        if ({core_rvalid, core_err, core_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL core_rd_rsp: got %b %b %h expected 1 0 deadbeef", core_rvalid, core_err, core_rdata);
        end
        idle();
        tick();
        checks++;
        if (core_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL core_rvalid_drop: got %b expected 0", core_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'(i * 4);
            #1;
            checks++;
            if (core_gnt !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_gnt[%0d]: got %b expected 1", i, core_gnt);
            end
            tick();
            checks++;
            if ({core_rvalid, core_rdata} !== {1'b1, 32'h1000_0000 + 32'(i)}) begin
                errors++;
                $display("[TB] FAIL b2b_rsp[%0d]: got %b %h expected 1 %h", i, core_rvalid, core_rdata, 32'h1000_0000 + 32'(i));
            end
        end
        idle();
        tick();
    endtask

    task automatic test_contention();
        logic exp_dma;
        core_req = 1'b1; core_addr = 32'h40;
        dma_req  = 1'b1; dma_addr  = 32'h44;
        for (int i = 0; i < 10; i++) begin
            exp_dma = (i % 5 == 4);
            #1;
            checks++;
            if ({core_gnt, dma_gnt} !== {!exp_dma, exp_dma}) begin
                errors++;
                $display("[TB] FAIL contention_gnt[%0d]: got core=%b dma=%b expected core=%b dma=%b", i, core_gnt, dma_gnt, !exp_dma, exp_dma);
            end
            tick();
            checks++;
            if ({core_rvalid, dma_rvalid} !== {!exp_dma, exp_dma}) begin
                errors++;
                $display("[TB] FAIL contention_rvalid[%0d]: got core=%b dma=%b expected core=%b dma=%b", i, core_rvalid, dma_rvalid, !exp_dma, exp_dma);
            end
            if (exp_dma) begin
                checks++;
                if (dma_rdata !== 32'h1000_0011) begin
                    errors++;
                    $display("[TB] FAIL contention_dma_rdata[%0d]: got %h expected 10000011", i, dma_rdata);
                end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_misaligned_dma();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h13;
        #1;
        checks++;
        if ({dma_gnt, MemRead, MemWrite} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL misaligned_strobe: got %b expected 100", {dma_gnt, MemRead, MemWrite});
        end
        tick();
        checks++;
        if ({dma_rvalid, dma_err, dma_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            errors++;
            $display("[TB] FAIL misaligned_rsp: got %b %b %h expected 1 1 0", dma_rvalid, dma_err, dma_rdata);
        end
        idle();
        tick();
        checks++;
        if ({dma_rvalid, dma_err} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL misaligned_drop: got %b expected 00", {dma_rvalid, dma_err});
        end
    endtask

    task automatic test_out_of_range();
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h400; core_wdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if ({core_gnt, MemWrite, MemRead} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL oor_strobe: got %b expected 100", {core_gnt, MemWrite, MemRead});
        end
        tick();
        checks++;
        if ({core_rvalid, core_err} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL oor_rsp: got %b expected 11", {core_rvalid, core_err});
        end
        checks++;
        if (mem[0] !== 32'h1000_0000) begin
            errors++;
            $display("[TB] FAIL oor_mem0: got %h expected 10000000", mem[0]);
        end
        idle();
        tick();
    endtask

    task automatic test_addr_table();
        logic [31:0] addrs [5];
        logic        exp_err;
        addrs = '{32'h3FC, 32'h400, 32'h2, 32'hFFFF_FFFC, 32'h104};
        for (int i = 0; i < 5; i++) begin
            exp_err  = !addr_ok(addrs[i], MEM_WORDS_DEFAULT);
            dma_req  = 1'b1; dma_we = 1'b0; dma_addr = addrs[i];
            #1;
            checks++;
            if (MemRead !== !exp_err) begin
                errors++;
                $display("[TB] FAIL addr_memread[%h]: got %b expected %b", addrs[i], MemRead, !exp_err);
            end
            tick();
            checks++;
            if ({dma_err, dma_rdata} !== {exp_err, exp_err ? 32'h0 : 32'h1000_0000 + 32'(addrs[i][9:2])}) begin
                errors++;
                $display("[TB] FAIL addr_rsp[%h]: got %b %h expected err=%b", addrs[i], dma_err, dma_rdata, exp_err);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_cross_port();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h55AA_55AA;
        #1;
        checks++;
        if ({dma_gnt, MemWrite} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL cross_dma_wr: got %b expected 11", {dma_gnt, MemWrite});
        end
        tick();
        idle();
        core_req = 1'b1; core_addr = 32'h20;
        #1;
        checks++;
        if ({core_gnt, MemRead, dma_rvalid, dma_err} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL cross_core_rd: got %b expected 1110", {core_gnt, MemRead, dma_rvalid, dma_err});
        end
        tick();
        checks++;
        if ({core_rvalid, core_rdata} !== {1'b1, 32'h55AA_55AA}) begin
            errors++;
            $display("[TB] FAIL cross_rdata: got %b %h expected 1 55aa55aa", core_rvalid, core_rdata);
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        logic exp_dma;
        // Build up DMA starvation, then reset while a core read is in flight.
        core_req = 1'b1; core_addr = 32'h10;
        dma_req  = 1'b1; dma_addr  = 32'h24;
        tick();
        tick();
        #1;
        checks++;
        if (core_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_gnt: got %b expected 1", core_gnt);
        end
        #2 rst_n = 1'b0;
        idle();
        #1;
        checks++;
        if ({core_rvalid, core_rdata} !== 33'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got %b %h expected 0 0", core_rvalid, core_rdata);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (core_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_rvalid: got %b expected 0", core_rvalid);
        end
        core_req = 1'b1; core_addr = 32'h10;
        dma_req  = 1'b1; dma_addr  = 32'h24;
        for (int j = 0; j < 5; j++) begin
            exp_dma = (j == 4);
            #1;
            checks++;
            if ({core_gnt, dma_gnt} !== {!exp_dma, exp_dma}) begin
                errors++;
                $display("[TB] FAIL rstmid_starve[%0d]: got core=%b dma=%b expected core=%b dma=%b", j, core_gnt, dma_gnt, !exp_dma, exp_dma);
            end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_core_only();
        test_back_to_back();
        test_contention();
        test_misaligned_dma();
        test_out_of_range();
        test_addr_table();
        test_cross_port();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port word-addressed data memory between the core load/store path and a DMA port. Grants one access per cycle with core priority and bounded DMA starvation, and screens misaligned or out-of-range addresses before they reach memory. Drives the memory's `MemRead`/`MemWrite`/address/write-data inputs and returns registered responses to each requester. Sits between the core/DMA and the data memory.

## Interface
- `MEM_WORDS`, 256: number of 32-bit words in memory; the word index is `addr[log2(MEM_WORDS)+1:2]`.
- `MAX_WAIT`, 4: maximum number of consecutive cycles a pending DMA request may be denied; range 1..15.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `core_req`, `core_we` in 1 each: core access request and write enable.
- `core_addr`, `core_wdata` in 32 each: core byte address and store data.
- `core_gnt` out 1: core request accepted this cycle; the core holds its request while this is low.
- `core_rvalid`, `core_err` out 1 each: response valid and error flag.
- `core_rdata` out 32: load data.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`, `dma_err`, `dma_rdata`: same as the core port, for the DMA requester.
- `MemRead`, `MemWrite` out 1 each: memory read and write strobes.
- `mem_addr`, `mem_write_data` out 32 each: memory address and write data.
- `mem_read_data` in 32: combinational read data from memory.

## Operation
- **Arbitration (combinational per cycle):**
  - Only one request is asserted: grant it.
  - Both are asserted: the core wins unless `starve_cnt == MAX_WAIT`, in which case the DMA wins.
  - No request: no grant.
  - At most one of `core_gnt`/`dma_gnt` is high in any cycle.
- **`starve_cnt`** (4 bits):
  - Increments when `dma_req && !dma_gnt`, saturating at `MAX_WAIT`.
  - Clears to 0 when `dma_gnt` is high or `dma_req` is low.
- **Address check on the granted request:**
  - Error if `addr[1:0] != 0` or `addr >= MEM_WORDS*4`.
  - An erroring request is still granted and consumed, but `MemRead` and `MemWrite` stay low.
- **Memory side:**
  - `MemRead = gnt && !we && !err`; `MemWrite = gnt && we && !err`.
  - `mem_addr` and `mem_write_data` carry the granted request's address and data; both are 0 when there is no grant.
- **Response registers** (per port), updated at the grant edge:
  - `rvalid` is set to 1.
  - `err` is set to the address-check result.
  - `rdata` captures `mem_read_data` for a valid read; it is 0 for writes and errors.
  - Both `rvalid` and `err` drop the following cycle unless there is a new grant.
- The memory write commits at the same edge that the response registers update.

## Timing
- Grant has zero latency: `gnt` is combinational from `req` in the same cycle.
- Response appears exactly 1 cycle after the grant (`rvalid` is high in cycle N+1 for a grant in cycle N).
- Back-to-back grants to the same port give back-to-back `rvalid`, with one access per cycle sustained.
- Under contention, DMA waits at most `MAX_WAIT` cycles and is granted in cycle `MAX_WAIT+1`.
- A read following a write to the same address in the next cycle returns the new data, because the write commits before the read.
- Reset, asynchronous:
  - All registered outputs (`*_rvalid`, `*_err`, `*_rdata`) go to 0 and `starve_cnt` goes to 0.
  - Combinational outputs follow the inputs; with no requests they are 0.
  - A response pending when reset asserts is dropped. Requesters must reissue after `rst_n` rises.
- A request withdrawn before it is granted is lost silently and does not count toward `starve_cnt` once `dma_req` is low.

## Structure
- Shared package `dmem_pkg`:
  - constant `MEM_WORDS_DEFAULT = 256`;
  - enum `req_id_t {REQ_NONE, REQ_CORE, REQ_DMA}`;
  - function `addr_ok(addr, words)`, used by both RTL and bench.
- Sub-module `dmem_addr_check`: combinational; takes addr and produces `err` and the word index.
- Top level holds the grant mux, `starve_cnt`, and two identical response-register sets.

## Test plan
- **Core-only traffic:** core writes `0xDEADBEEF` to `0x10`, then reads `0x10`. `MemWrite` is high for 1 cycle; the read gives `core_rvalid` in the next cycle with `core_rdata = 0xDEADBEEF`.
- **Continuous contention:** both request continuously with `MAX_WAIT = 4`. Core is granted for cycles 0–3 and DMA in cycle 4; the pattern repeats with period 5 and `starve_cnt` never exceeds 4.
- **Misaligned DMA access:** DMA reads `0x13`. `dma_gnt = 1` with `MemRead = 0`; in the next cycle `dma_rvalid = 1`, `dma_err = 1`, `dma_rdata = 0`.
- **Out-of-range core write:** core writes `0x400` (`MEM_WORDS = 256`). `core_err = 1`, `MemWrite` never asserts, and memory word 0 is unchanged.
- **Reset mid-operation:** a read is granted at cycle N and `rst_n` drops before edge N+1. `core_rvalid` stays 0 after reset releases and `starve_cnt = 0`.
- **Write then read across ports:** DMA writes `0x55AA55AA` to `0x20`, then core reads `0x20` in the next cycle and gets `0x55AA55AA`.
